// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two one-entry buffers (ALU, load) share the register file write port.
// Optional WB_ROUND_ROBIN_EN selects round-robin for different-address contention; default is fixed priority to port 0.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb0_valid,
    output logic                     wb0_ready,
    input  logic [ADDR_WIDTH-1:0]    wb0_addr,
    input  logic [DATA_WIDTH-1:0]    wb0_data,
    input  logic                     wb1_valid,
    output logic                     wb1_ready,
    input  logic [ADDR_WIDTH-1:0]    wb1_addr,
    input  logic [DATA_WIDTH-1:0]    wb1_data,
    output logic [ADDR_WIDTH-1:0]    write_address_0,
    output logic                     write_en,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic [2**ADDR_WIDTH-1:0] pend_mask
);
    logic                  r_full0, r_full1;
    logic                  r_age0, r_age1;
    logic [ADDR_WIDTH-1:0] r_addr0, r_addr1;
    logic [DATA_WIDTH-1:0] r_data0, r_data1;

    logic                    w_gnt0, w_gnt1;
    logic                    w_load0, w_load1;
    logic                    w_full0_n, w_full1_n;
    logic                    w_age0_n, w_age1_n;
    logic [ADDR_WIDTH-1:0]   w_addr0_n, w_addr1_n, w_waddr_n;
    logic [2**ADDR_WIDTH-1:0] w_mask_n;

`ifdef WB_ROUND_ROBIN_EN
    logic r_last1;
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_full0 && r_full1) begin
            if (r_addr0 == r_addr1) begin
                // age bit set means the other entry to the same register is older
                if (r_age0) w_gnt1 = 1'b1;
                else        w_gnt0 = 1'b1;
            end else begin
`ifdef WB_ROUND_ROBIN_EN
                if (r_last1) w_gnt0 = 1'b1;
                else         w_gnt1 = 1'b1;
`else
                w_gnt0 = 1'b1;
`endif
            end
        end else begin
            w_gnt0 = r_full0;
            w_gnt1 = r_full1;
        end
    end

    assign wb0_ready = !r_full0 || w_gnt0;
    assign wb1_ready = !r_full1 || w_gnt1;

    // writes to r0 finish the handshake but never occupy a buffer
    assign w_load0 = wb0_valid && wb0_ready && (wb0_addr != '0);
    assign w_load1 = wb1_valid && wb1_ready && (wb1_addr != '0);

    assign w_full0_n = w_load0 || (r_full0 && !w_gnt0);
    assign w_full1_n = w_load1 || (r_full1 && !w_gnt1);
    assign w_addr0_n = w_load0 ? wb0_addr : r_addr0;
    assign w_addr1_n = w_load1 ? wb1_addr : r_addr1;

    // An entry is younger only while the other buffer keeps the entry it held at capture.
    assign w_age0_n = w_load0 ? (r_full1 && !w_gnt1) : (r_age0 && !w_gnt1 && !w_load1);
    assign w_age1_n = w_load1 ? (r_full0 && !w_gnt0) : (r_age1 && !w_gnt0 && !w_load0);

    assign w_waddr_n = w_gnt0 ? r_addr0 : r_addr1;

    always_comb begin
        w_mask_n = '0;
        if (w_full0_n)        w_mask_n[w_addr0_n] = 1'b1;
        if (w_full1_n)        w_mask_n[w_addr1_n] = 1'b1;
        if (w_gnt0 || w_gnt1) w_mask_n[w_waddr_n] = 1'b1;
        w_mask_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full0         <= 1'b0;
            r_full1         <= 1'b0;
            r_age0          <= 1'b0;
            r_age1          <= 1'b0;
            r_addr0         <= '0;
            r_addr1         <= '0;
            r_data0         <= '0;
            r_data1         <= '0;
            write_en        <= 1'b0;
            write_address_0 <= '0;
            write_data      <= '0;
            pend_mask       <= '0;
        end else begin
            r_full0   <= w_full0_n;
            r_full1   <= w_full1_n;
            r_age0    <= w_age0_n;
            r_age1    <= w_age1_n;
            r_addr0   <= w_addr0_n;
            r_addr1   <= w_addr1_n;
            if (w_load0) r_data0 <= wb0_data;
            if (w_load1) r_data1 <= wb1_data;
            write_en  <= w_gnt0 || w_gnt1;
            if (w_gnt0 || w_gnt1) begin
                write_address_0 <= w_waddr_n;
                write_data      <= w_gnt0 ? r_data0 : r_data1;
            end
            pend_mask <= w_mask_n;
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)                   r_last1 <= 1'b1;
        else if (w_gnt0 || w_gnt1) r_last1 <= w_gnt1;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued by stimulus and
// popped by a negedge monitor whenever write_en is high.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb0_valid, wb1_valid;
    logic          wb0_ready, wb1_ready;
    logic [AW-1:0] wb0_addr, wb1_addr;
    logic [DW-1:0] wb0_data, wb1_data;
    logic [AW-1:0] write_address_0;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic [31:0]   pend_mask;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .write_address_0(write_address_0), .write_en(write_en), .write_data(write_data),
        .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0d/%0d expected=none", write_address_0, write_data);
            end else begin
                e = exp_q.pop_front();
                chk("write", {27'd0, write_address_0, write_data}, {27'd0, e.a, e.d});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Holds each request until a handshake is seen (ready sampled at negedge, state-only dependent).
    task automatic drive(input int port, input int n, input logic [AW-1:0] base_a, input logic [DW-1:0] base_d);
        logic acc;
        int   guard;
        for (int i = 0; i < n; i++) begin
            if (port == 0) begin
                wb0_valid = 1'b1; wb0_addr = base_a + AW'(i); wb0_data = base_d + DW'(i);
            end else begin
                wb1_valid = 1'b1; wb1_addr = base_a + AW'(i); wb1_data = base_d + DW'(i);
            end
            guard = 0;
            do begin
                @(negedge clk);
                acc = (port == 0) ? wb0_ready : wb1_ready;
                @(posedge clk);
                #1;
                guard++;
            end while (!acc && guard < 50);
            if (!acc) chk("drive_timeout", 64'(guard), 64'd0);
        end
        if (port == 0) wb0_valid = 1'b0;
        else           wb1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        wb0_addr = '0; wb0_data = '0; wb1_addr = '0; wb1_data = '0;
        do_reset();
        step();

        // reset state
        chk("rst_we", 64'(write_en), 64'd0);
        chk("rst_addr", 64'(write_address_0), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);
        chk("rst_mask", 64'(pend_mask), 64'd0);
        chk("rst_rdy", {62'd0, wb0_ready, wb1_ready}, 64'd3);

        // single port 0 write: addr 3, data 175
        wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'd175;
        push(5'd3, 32'd175);
        step();
        wb0_valid = 1'b0;
        chk("t1_we_cap", 64'(write_en), 64'd0);
        chk("t1_mask_a", 64'(pend_mask), 64'h8);
        step();
        chk("t1_we_on", 64'(write_en), 64'd1);
        chk("t1_mask_b", 64'(pend_mask), 64'h8);
        step();
        chk("t1_we_off", 64'(write_en), 64'd0);
        chk("t1_mask_c", 64'(pend_mask), 64'd0);

        // simultaneous different addresses: port 0 first in both builds
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 5'd2; wb0_data = 32'd190;
        wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'd55;
        push(5'd2, 32'd190);
        push(5'd9, 32'd55);
        step();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        chk("t2_rdy", {62'd0, wb0_ready, wb1_ready}, 64'd2);
        chk("t2_mask", 64'(pend_mask), 64'h204);
        step();
        chk("t2_rdy1", 64'(wb1_ready), 64'd1);
        repeat (3) step();

        // both ports stream 8 writes to different addresses
        do_reset();
`ifdef WB_ROUND_ROBIN_EN
        for (int i = 0; i < 8; i++) begin
            push(5'd1 + 5'(i), 32'd100 + 32'(i));
            push(5'd17 + 5'(i), 32'd200 + 32'(i));
        end
`else
        for (int i = 0; i < 8; i++) push(5'd1 + 5'(i), 32'd100 + 32'(i));
        for (int i = 0; i < 8; i++) push(5'd17 + 5'(i), 32'd200 + 32'(i));
`endif
        fork
            drive(0, 8, 5'd1, 32'd100);
            drive(1, 8, 5'd17, 32'd200);
        join
        repeat (4) step();
        chk("t3_drained", 64'(exp_q.size()), 64'd0);

        // same address: port 1's older entry (data 1) is written before port 0's (data 2)
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'd70;
        wb1_valid = 1'b1; wb1_addr = 5'd5; wb1_data = 32'd1;
        push(5'd7, 32'd70);
        push(5'd5, 32'd1);
        push(5'd5, 32'd2);
        step();
        wb1_valid = 1'b0;
        wb0_addr = 5'd5; wb0_data = 32'd2;
        chk("t4_rdy_a", {62'd0, wb0_ready, wb1_ready}, 64'd2);
        step();
        wb0_valid = 1'b0;
        chk("t4_rdy_b", {62'd0, wb0_ready, wb1_ready}, 64'd1);
        chk("t4_mask", 64'(pend_mask), 64'hA0);
        step();
        chk("t4_mask_b", 64'(pend_mask), 64'h20);
        repeat (3) step();
        chk("t4_mask_c", 64'(pend_mask), 64'd0);

        // address 0 is accepted and dropped
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'd99;
        chk("t5_rdy", 64'(wb0_ready), 64'd1);
        step();
        wb0_valid = 1'b0;
        chk("t5_mask", 64'(pend_mask), 64'd0);
        chk("t5_rdy_after", 64'(wb0_ready), 64'd1);
        step();
        chk("t5_we", 64'(write_en), 64'd0);

        // reset with both buffers full drops everything
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 5'd10; wb0_data = 32'd1;
        wb1_valid = 1'b1; wb1_addr = 5'd11; wb1_data = 32'd2;
        step();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        chk("t6_mask_pre", 64'(pend_mask), 64'hC00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_we", 64'(write_en), 64'd0);
        chk("t6_mask", 64'(pend_mask), 64'd0);
        chk("t6_rdy", {62'd0, wb0_ready, wb1_ready}, 64'd3);
        repeat (4) step();
        chk("t6_mask_late", 64'(pend_mask), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the single register file write port between two write-back requesters: port 0 is the ALU result and port 1 is the load result. Each requester hands off an (address, data) pair over a valid/ready handshake into a one-entry holding buffer. The arbiter grants one buffer per cycle and drives the registered `write_address_0` / `write_en` / `write_data` inputs of `RegisterFile`. It also exports a pending-write mask for hazard detection in decode.

## Interface
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register address width; the file has 2**ADDR_WIDTH entries

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wb0_valid`  in  1  ALU write-back request
- `wb0_ready`  out  1  port 0 buffer can accept this cycle
- `wb0_addr`  in  ADDR_WIDTH  destination register
- `wb0_data`  in  DATA_WIDTH  result
- `wb1_valid`, `wb1_ready`, `wb1_addr`, `wb1_data`: same as port 0, for the load unit
- `write_address_0`  out  ADDR_WIDTH  to RegisterFile, registered
- `write_en`  out  1  to RegisterFile, registered
- `write_data`  out  DATA_WIDTH  to RegisterFile, registered
- `pend_mask`  out  2**ADDR_WIDTH  bit r set while a write to r sits in a buffer or the output register

## Operation
- Handshake: a transfer occurs on any edge where `wbN_valid && wbN_ready`. A requester holds addr and data stable while valid is high and ready is low.
- `wbN_ready = !bufN_full || grantN`. A buffer may refill on the same edge it drains.
- Address 0 requests complete the handshake but are discarded: the buffer is not loaded and no write is issued.
- Each buffer stores addr, data and an age bit. The age bit is set when the other buffer was already full at capture time.
- Grant, evaluated combinationally each cycle from buffer state:
  - Only one buffer full: grant it.
  - Both full, same address: grant the older one (age bit clear). If both were captured on the same edge, port 0 is older.
  - Both full, different addresses: apply the policy selected under Configuration.
- On an edge with a grant, the output registers load the granted entry with `write_en`=1 and that buffer empties unless it is refilled on the same edge. On an edge with no grant, `write_en` loads 0; address and data hold their previous values.
- `pend_mask` is registered, recomputed every edge from next-state buffers and output register; bit 0 is always 0.
- Reset values: buffers empty, age bits 0, `write_en`=0, `write_address_0`=0, `write_data`=0, `pend_mask`=0, round-robin pointer = "port 1 last granted".
- Reset mid-operation: every buffered or in-flight write is dropped, with no partial write. Both ready outputs go high in the first cycle after reset.

## Timing
- Handshake at edge N, buffer empty, no contention: `write_en`=1 with that addr/data in cycle N+1 to N+2. RegisterFile commits at edge N+2.
- Throughput: one write per cycle total. Each port sustains one transfer per cycle when uncontended.
- Under contention, the losing port's ready is low for exactly one cycle per lost grant.
- The `pend_mask` bit for an address rises the cycle after the handshake and falls the cycle after the last `write_en` for that address.

## Configuration
- `WB_ROUND_ROBIN_EN` defined: for different-address contention, grant the port not granted most recently. The pointer updates on every grant.
- Not defined: fixed priority, where port 0 always wins different-address contention. The pointer logic is removed.
- The same-address age ordering applies in both builds.

## Test plan
- After reset, single port 0 write (addr 3, data 175) at edge N -> `write_en`=1, `write_address_0`=3, `write_data`=175 in cycle N+1 only; `pend_mask[3]` high for cycles N+1 to N+2.
- Simultaneous port 0 (addr 2, data 190) and port 1 (addr 9, data 55) -> writes issued on consecutive cycles. Port 0 goes first in both builds, since the round-robin pointer resets to "port 1 last". `wb1_ready` is low for one cycle.
- Both ports stream continuously for 8 cycles to different addresses -> with `WB_ROUND_ROBIN_EN`, grants alternate 0,1,0,1…; without it, port 1 never writes until port 0 stops.
- Port 1 captures addr 5 (data 1) one cycle before port 0 captures addr 5 (data 2) while the output is busy -> data 1 is written, then data 2. The final register value is 2.
- Port 0 request to addr 0 -> handshake completes, `write_en` stays 0, `pend_mask` stays 0.
- Both buffers full, assert `rst` for one cycle -> `write_en`=0 and `pend_mask`=0 after the edge, neither buffered write ever appears, and both readies are high.
